// File: rtl/rv32_pkg.sv
// ============================================================================
// Package : rv32_pkg
// Brief   : Shared register-file widths and the write-back entry type.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
// ============================================================================
// Module  : wb_fifo
// Brief   : Pending write-back queue, up to two pushes and one pop per edge.
//           With WB_FWD_EN defined, raw storage and read pointer are exported.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_fifo
  import rv32_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             push_n,
  input  wb_entry_t              push_a,
  input  wb_entry_t              push_b,
  input  logic                   pop,
  output wb_entry_t              head,
  output logic [CNT_W-1:0]       count
`ifdef WB_FWD_EN
 ,output wb_entry_t [DEPTH-1:0]  entries,
  output logic [PTR_W-1:0]       rd_ptr
`endif
);

  wb_entry_t [DEPTH-1:0] r_mem;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  // Storage needs no reset: only entries below count are ever observed.
  always_ff @(posedge clk) begin
    if (push_n != 2'd0) r_mem[r_wr_ptr] <= push_a;
    if (push_n == 2'd2) r_mem[r_wr_ptr + PTR_W'(1)] <= push_b;
  end

  // Pointer arithmetic wraps naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(push_n);
      r_rd_ptr <= r_rd_ptr + PTR_W'(pop);
      r_count  <= r_count + CNT_W'(push_n) - CNT_W'(pop);
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

`ifdef WB_FWD_EN
  assign entries = r_mem;
  assign rd_ptr  = r_rd_ptr;
`endif

endmodule

`default_nettype wire

// File: rtl/wb_arbiter.sv
// ============================================================================
// Module  : wb_arbiter
// Brief   : Merges load-unit and ALU results into one register-file write
//           port, oldest first, buffering the overflow in wb_fifo.
//           Optional macro WB_FWD_EN adds two forwarding lookup ports.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_arbiter
  import rv32_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]       mem_data,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  output logic                  in_ready,
  output logic                  RegWriteEn,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [XLEN-1:0]       data
`ifdef WB_FWD_EN
 ,input  logic [REG_ADDR_W-1:0] read_r1,
  input  logic [REG_ADDR_W-1:0] read_r2,
  output logic                  fwd_hit1,
  output logic                  fwd_hit2,
  output logic [XLEN-1:0]       fwd_data1,
  output logic [XLEN-1:0]       fwd_data2
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             w_mem_acc;
  logic             w_alu_acc;
  wb_entry_t        w_mem_e;
  wb_entry_t        w_alu_e;
  logic             w_emit;
  wb_entry_t        w_sel;
  logic             w_pop;
  logic [1:0]       w_push_n;
  wb_entry_t        w_push_a;
  wb_entry_t        w_push_b;
  wb_entry_t        w_head;
  logic [CNT_W-1:0] w_count;

  // Two free slots are always guaranteed whenever both sources may be taken.
  assign in_ready  = (w_count <= CNT_W'(DEPTH - 2));
  assign w_mem_acc = mem_valid & in_ready;
  assign w_alu_acc = alu_valid & in_ready;
  assign w_mem_e   = '{rd: mem_rd, data: mem_data};
  assign w_alu_e   = '{rd: alu_rd, data: alu_data};

  always_comb begin
    w_emit   = 1'b0;
    w_sel    = w_head;
    w_pop    = 1'b0;
    w_push_n = 2'd0;
    w_push_a = w_mem_e;
    w_push_b = w_alu_e;
    if (w_count != '0) begin
      w_emit = 1'b1;
      w_pop  = 1'b1;
      if (w_mem_acc && w_alu_acc) begin
        w_push_n = 2'd2;
      end else if (w_mem_acc) begin
        w_push_n = 2'd1;
      end else if (w_alu_acc) begin
        w_push_n = 2'd1;
        w_push_a = w_alu_e;
      end
    end else if (w_mem_acc) begin
      w_emit = 1'b1;
      w_sel  = w_mem_e;
      if (w_alu_acc) begin
        w_push_n = 2'd1;
        w_push_a = w_alu_e;
      end
    end else if (w_alu_acc) begin
      w_emit = 1'b1;
      w_sel  = w_alu_e;
    end
  end

`ifdef WB_FWD_EN
  localparam int PTR_W = $clog2(DEPTH);
  wb_entry_t [DEPTH-1:0] w_entries;
  logic [PTR_W-1:0]      w_rd_ptr;
`endif

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_n  (w_push_n),
    .push_a  (w_push_a),
    .push_b  (w_push_b),
    .pop     (w_pop),
    .head    (w_head),
    .count   (w_count)
`ifdef WB_FWD_EN
   ,.entries (w_entries),
    .rd_ptr  (w_rd_ptr)
`endif
  );

  // x0 results still occupy their slot; only the write enable is suppressed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteEn <= 1'b0;
      rd         <= '0;
      data       <= '0;
    end else begin
      RegWriteEn <= w_emit && (w_sel.rd != '0);
      if (w_emit) begin
        rd   <= w_sel.rd;
        data <= w_sel.data;
      end
    end
  end

`ifdef WB_FWD_EN
  logic [REG_ADDR_W-1:0] w_read_addr [2];
  assign w_read_addr[0] = read_r1;
  assign w_read_addr[1] = read_r2;

  // Scan oldest to youngest so the youngest match overrides earlier ones.
  for (genvar p = 0; p < 2; p++) begin : g_fwd
    logic             hit;
    logic [XLEN-1:0]  fdata;
    logic [PTR_W-1:0] idx;
    always_comb begin
      hit   = 1'b0;
      fdata = '0;
      idx   = '0;
      if (w_read_addr[p] != '0) begin
        if (RegWriteEn && (rd == w_read_addr[p])) begin
          hit   = 1'b1;
          fdata = data;
        end
        for (int i = 0; i < DEPTH; i++) begin
          idx = w_rd_ptr + PTR_W'(i);
          if ((i < int'(w_count)) && (w_entries[idx].rd == w_read_addr[p])) begin
            hit   = 1'b1;
            fdata = w_entries[idx].data;
          end
        end
      end
    end
  end

  assign fwd_hit1  = g_fwd[0].hit;
  assign fwd_data1 = g_fwd[0].fdata;
  assign fwd_hit2  = g_fwd[1].hit;
  assign fwd_data2 = g_fwd[1].fdata;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
// ============================================================================
// Module  : tb_wb_arbiter
// Brief   : Self-checking bench for wb_arbiter against a queue-based model.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_arbiter;
  import rv32_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid = 1'b0;
  logic [4:0]  mem_rd = '0;
  logic [31:0] mem_data = '0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        in_ready;
  logic        RegWriteEn;
  logic [4:0]  rd;
  logic [31:0] data;
`ifdef WB_FWD_EN
  logic [4:0]  read_r1 = '0;
  logic [4:0]  read_r2 = '0;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data1, fwd_data2;
`endif

  wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_valid  (mem_valid),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .in_ready   (in_ready),
    .RegWriteEn (RegWriteEn),
    .rd         (rd),
    .data       (data)
`ifdef WB_FWD_EN
   ,.read_r1    (read_r1),
    .read_r2    (read_r2),
    .fwd_hit1   (fwd_hit1),
    .fwd_hit2   (fwd_hit2),
    .fwd_data1  (fwd_data1),
    .fwd_data2  (fwd_data2)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: every accepted, not-yet-written result in age order.
  wb_entry_t   mq[$];
  logic        exp_we = 1'b0;
  logic [4:0]  exp_rd = '0;
  logic [31:0] exp_data = '0;
  logic        exp_ready = 1'b1;
  logic        obs_ready = 1'b0;

  task automatic model_reset();
    mq.delete();
    exp_we   = 1'b0;
    exp_rd   = '0;
    exp_data = '0;
  endtask

  // Drives one cycle of source inputs, advances the model, ends at edge+1.
  task automatic cycle(input logic mv, input logic [4:0] mr, input logic [31:0] md,
                       input logic av, input logic [4:0] ar, input logic [31:0] ad);
    wb_entry_t e;
    mem_valid = mv; mem_rd = mr; mem_data = md;
    alu_valid = av; alu_rd = ar; alu_data = ad;
    #1;
    obs_ready = in_ready;
    exp_ready = (mq.size() <= DEPTH - 2);
    if (exp_ready && mv) mq.push_back('{rd: mr, data: md});
    if (exp_ready && av) mq.push_back('{rd: ar, data: ad});
    if (mq.size() > 0) begin
      e        = mq.pop_front();
      exp_we   = (e.rd != 5'd0);
      exp_rd   = e.rd;
      exp_data = e.data;
    end else begin
      exp_we = 1'b0;
    end
    @(posedge clk);
    #1;
    mem_valid = 1'b0;
    alu_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if (RegWriteEn !== 1'b0 || rd !== 5'd0 || data !== 32'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: got we=%0b rd=%0d data=%h rdy=%0b, expected 0 0 0 1",
               RegWriteEn, rd, data, in_ready);
    end
    @(posedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic test_single();
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'd45);
    checks++;
    if (RegWriteEn !== 1'b1 || rd !== 5'd3 || data !== 32'd45) begin
      errors++;
      $display("FAIL single: got we=%0b rd=%0d data=%0d, expected we=1 rd=3 data=45",
               RegWriteEn, rd, data);
    end
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checks++;
    if (RegWriteEn !== 1'b0 || rd !== 5'd3 || data !== 32'd45) begin
      errors++;
      $display("FAIL single_idle: got we=%0b rd=%0d data=%0d, expected we=0 rd=3 data=45",
               RegWriteEn, rd, data);
    end
  endtask

  task automatic test_same_edge();
    cycle(1'b1, 5'd2, 32'd8, 1'b1, 5'd2, 32'd9);
    checks++;
    if (RegWriteEn !== 1'b1 || rd !== 5'd2 || data !== 32'd8) begin
      errors++;
      $display("FAIL same_edge_mem: got we=%0b rd=%0d data=%0d, expected we=1 rd=2 data=8",
               RegWriteEn, rd, data);
    end
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checks++;
    if (RegWriteEn !== 1'b1 || rd !== 5'd2 || data !== 32'd9) begin
      errors++;
      $display("FAIL same_edge_alu: got we=%0b rd=%0d data=%0d, expected we=1 rd=2 data=9",
               RegWriteEn, rd, data);
    end
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checks++;
    if (RegWriteEn !== 1'b0) begin
      errors++;
      $display("FAIL same_edge_idle: got we=%0b, expected we=0", RegWriteEn);
    end
  endtask

  task automatic test_x0();
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD);
    checks++;
    if (RegWriteEn !== 1'b0) begin
      errors++;
      $display("FAIL x0_we: got we=%0b, expected we=0", RegWriteEn);
    end
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77);
    checks++;
    if (RegWriteEn !== 1'b1 || rd !== 5'd7 || data !== 32'h77) begin
      errors++;
      $display("FAIL x0_next: got we=%0b rd=%0d data=%h, expected we=1 rd=7 data=77",
               RegWriteEn, rd, data);
    end
  endtask

  task automatic test_back_to_back();
    int mi = 0, ai = 0, emitted = 0;
    logic saw_low = 1'b0;
    for (int c = 0; c < 60; c++) begin
      cycle(mi < 10, 5'((mi % 31) + 1), 32'h1000 + mi,
            ai < 10, 5'(((ai + 7) % 31) + 1), 32'h2000 + ai);
      if (!obs_ready) saw_low = 1'b1;
      checks++;
      if (obs_ready !== exp_ready) begin
        errors++;
        $display("FAIL b2b_ready: cycle %0d got %0b, expected %0b", c, obs_ready, exp_ready);
      end
      checks++;
      if (RegWriteEn !== exp_we || rd !== exp_rd || data !== exp_data) begin
        errors++;
        $display("FAIL b2b_out: cycle %0d got we=%0b rd=%0d data=%h, expected we=%0b rd=%0d data=%h",
                 c, RegWriteEn, rd, data, exp_we, exp_rd, exp_data);
      end
      if (exp_ready) begin
        if (mi < 10) mi++;
        if (ai < 10) ai++;
      end
      if (RegWriteEn === 1'b1) emitted++;
      if (mi == 10 && ai == 10 && mq.size() == 0) break;
    end
    checks++;
    if (emitted != 20 || saw_low !== 1'b1) begin
      errors++;
      $display("FAIL b2b_total: got writes=%0d ready_low=%0b, expected writes=20 ready_low=1",
               emitted, saw_low);
    end
  endtask

  task automatic test_random();
    logic mp = 1'b0, ap = 1'b0;
    logic [4:0]  mr = '0, ar = '0;
    logic [31:0] md = '0, ad = '0;
    for (int c = 0; c < 300; c++) begin
      if (!mp && $urandom_range(1, 0) == 1) begin
        mp = 1'b1; mr = 5'($urandom_range(31, 0)); md = $urandom;
      end
      if (!ap && $urandom_range(2, 0) != 0) begin
        ap = 1'b1; ar = 5'($urandom_range(31, 0)); ad = $urandom;
      end
      cycle(mp, mr, md, ap, ar, ad);
      checks++;
      if (obs_ready !== exp_ready) begin
        errors++;
        $display("FAIL rand_ready: cycle %0d got %0b, expected %0b", c, obs_ready, exp_ready);
      end
      checks++;
      if (RegWriteEn !== exp_we || rd !== exp_rd || data !== exp_data) begin
        errors++;
        $display("FAIL rand_out: cycle %0d got we=%0b rd=%0d data=%h, expected we=%0b rd=%0d data=%h",
                 c, RegWriteEn, rd, data, exp_we, exp_rd, exp_data);
      end
      if (exp_ready) begin
        mp = 1'b0;
        ap = 1'b0;
      end
    end
    while (mq.size() > 0) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 3; c++)
      cycle(1'b1, 5'(10 + c), 32'hA0 + c, 1'b1, 5'(20 + c), 32'hB0 + c);
    checks++;
    if (mq.size() != 3 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_fill: got rdy=%0b, expected 0 with 3 pending (model %0d)",
               in_ready, mq.size());
    end
    rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if (RegWriteEn !== 1'b0 || rd !== 5'd0 || data !== 32'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid: got we=%0b rd=%0d data=%h rdy=%0b, expected 0 0 0 1",
               RegWriteEn, rd, data, in_ready);
    end
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      checks++;
      if (RegWriteEn !== 1'b0 || rd !== 5'd0 || data !== 32'd0) begin
        errors++;
        $display("FAIL rst_mid_drain: cycle %0d got we=%0b rd=%0d data=%h, expected 0 0 0",
                 c, RegWriteEn, rd, data);
      end
    end
  endtask

`ifdef WB_FWD_EN
  task automatic test_fwd();
    cycle(1'b1, 5'd5, 32'd7, 1'b1, 5'd5, 32'd11);
    read_r1 = 5'd5;
    read_r2 = 5'd0;
    #1;
    checks++;
    if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'd11) begin
      errors++;
      $display("FAIL fwd1: got hit=%0b data=%0d, expected hit=1 data=11", fwd_hit1, fwd_data1);
    end
    checks++;
    if (fwd_hit2 !== 1'b0 || fwd_data2 !== 32'd0) begin
      errors++;
      $display("FAIL fwd2: got hit=%0b data=%0d, expected hit=0 data=0", fwd_hit2, fwd_data2);
    end
    read_r1 = 5'd0;
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_same_edge();
    test_x0();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef WB_FWD_EN
    test_fwd();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
